keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad (Pmod KYPD style), debounces it and delivers a clean key code plus a single-cycle press strobe. It is the producer side of the game's keypad interface. `key` drives the game's `keypadButton` column select. `key_press` drives `btn_submit`; the game edge-detects it, so one strobe equals one move. It sits between the board-level keypad pins and the connect4 game core, in the same `clk` domain.

---
 rtl/kypd_pkg.sv | 28 ++
 rtl/keypad_scanner_sync_2ff.sv | 13 +
 rtl/keypad_scanner.sv | 82 ++++++++
 tb/tb_keypad_scanner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// kypd_pkg: shared key map, scan states and frame-result types for the keypad scanner
package kypd_pkg;
  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_cls_t;
  typedef struct packed {
    res_cls_t   cls;
    logic [3:0] code;
  } frame_res_t;
  // Indexed by {row, col}: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
  // Classify a full-matrix hit vector; code is forced to 0 unless exactly one key is down
  // so that results compare equal whenever their class and meaningful payload agree.
  function automatic frame_res_t reduce_frame(input logic [15:0] hits);
    frame_res_t r;
    logic [4:0] n;
    n = 5'($countones(hits));
    r.cls = n == 5'd0 ? RES_NONE : n == 5'd1 ? RES_SINGLE : RES_MULTI;
    r.code = 4'h0;
    for (int i = 0; i < 16; i++)
      if (n == 5'd1 && hits[i]) r.code = KEY_MAP[i];
    return r;
  endfunction
endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the keypad rows, idling high in reset
module sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  // Rows are pulled up, so reset to the idle (all released) level
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces whole frames and emits key code plus press strobe
module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_press,
  output logic       multi
);
  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  logic [3:0] rows_n;
  scan_state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stable, stable_nxt;
  logic [15:0] hits, hits_nxt;
  frame_res_t res, cand, cand_nxt, com;
  logic last, frame_end, same, commit;
  sync_2ff u_sync (.clk(clk), .reset(reset), .d(row_n), .q(rows_n));
  assign last = cnt == CW'(SCAN_CYCLES - 1);
  assign frame_end = last && state == COL3;
  // Fold the current column's rows into the frame; COL0 starts a fresh frame
  always_comb begin
    hits_nxt = state == COL0 ? 16'h0 : hits;
    for (int r = 0; r < 4; r++) hits_nxt[{2'(r), 2'(state)}] = ~rows_n[r];
  end
  // Frame classification and debounce decision, evaluated for use on the frame's last cycle
  always_comb begin
    res = reduce_frame(hits_nxt);
    com = '{cls: key_valid ? RES_SINGLE : multi ? RES_MULTI : RES_NONE, code: key_valid ? key : 4'h0};
    same = res == cand;
    cand_nxt = same ? cand : res;
    stable_nxt = !same ? SW'(1) : stable == SW'(DEBOUNCE_SCANS) ? stable : stable + 1'b1;
    commit = frame_end && stable_nxt == SW'(DEBOUNCE_SCANS) && cand_nxt != com;
  end
  // Column scan: hold each column for SCAN_CYCLES, rotate the active-low drive at state boundaries
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= COL0;
      cnt <= '0;
      col_n <= 4'b1110;
    end else if (last) begin
      state <= scan_state_t'(state + 2'd1);
      cnt <= '0;
      col_n <= {col_n[2:0], col_n[3]};
    end else cnt <= cnt + 1'b1;
  // Frame accumulator and debounce candidate tracking
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hits <= '0;
      cand <= '{cls: RES_NONE, code: 4'h0};
      stable <= '0;
    end else begin
      if (last) hits <= hits_nxt;
      if (frame_end) begin
        cand <= cand_nxt;
        stable <= stable_nxt;
      end
    end
  // Committed state drives the outputs; only a newly committed single key pulses
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      key <= 4'h0;
      key_valid <= 1'b0;
      multi <= 1'b0;
      key_press <= 1'b0;
    end else begin
      key_press <= commit && cand_nxt.cls == RES_SINGLE;
      if (commit) begin
        key_valid <= cand_nxt.cls == RES_SINGLE;
        multi <= cand_nxt.cls == RES_MULTI;
        if (cand_nxt.cls == RES_SINGLE) key <= cand_nxt.code;
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks of keypad_scanner against a frame-level reference model
module tb_keypad_scanner;
  localparam int SC = 8, DB = 3, FR = 4 * SC;
  logic clk = 1'b0, reset = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0] row_n, col_n, key;
  logic key_valid, key_press, multi;
  int n_chk = 0, n_err = 0;
  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int n, cc, ck, st, mc, mk, ekey, npress, p0, lat;
  bit epress;
  logic [15:0] fr, p1, p2;
  always #5 clk = ~clk;
  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .key(key),
    .key_valid(key_valid), .key_press(key_press), .multi(multi)
  );
  // Physical keypad: a pressed key shorts its row to a low-driven column
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r * 4 + c] && !col_n[c]) row_n[r] = 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    n = 0; cc = 0; ck = 0; st = 0; mc = 0; mk = 0; ekey = 0; epress = 0;
    fr = '0; p1 = '0; p2 = '0;
  endtask
  // Predict the edge about to happen: column c is read from pins as they were two edges earlier,
  // once per column at the end of its dwell; each frame is then classified and debounced.
  task automatic tick();
    int c, k, rc, rk;
    logic [3:0] ecol;
    epress = 0;
    if (n % SC == SC - 1) begin
      c = (n / SC) % 4;
      for (int r = 0; r < 4; r++) if (p2[r * 4 + c]) fr[r * 4 + c] = 1'b1;
    end
    if (n % FR == FR - 1) begin
      k = $countones(fr);
      rc = k == 0 ? 0 : k == 1 ? 1 : 2;
      rk = 0;
      for (int i = 0; i < 16; i++) if (k == 1 && fr[i]) rk = kmap[i];
      if (rc == cc && rk == ck) st = st < DB ? st + 1 : DB;
      else begin cc = rc; ck = rk; st = 1; end
      if (st == DB && (cc != mc || ck != mk)) begin
        mc = cc; mk = ck;
        if (cc == 1) begin ekey = ck; epress = 1; end
      end
      fr = '0;
    end
    p2 = p1; p1 = pressed;
    n++;
    @(posedge clk); #1;
    if (key_press) npress++;
    ecol = ~(4'b1 << ((n / SC) % 4));
    chk("col_n", col_n, ecol);
    chk("key", key, ekey);
    chk("key_valid", key_valid, mc == 1);
    chk("multi", multi, mc == 2);
    chk("key_press", key_press, epress);
  endtask
  task automatic run(input int cycles);
    repeat (cycles) tick();
  endtask
  task automatic align();
    while (n % FR != 0) tick();
  endtask
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key", key, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_press", key_press, 1'b0);
    chk("rst_multi", multi, 1'b0);
    model_reset();
    @(negedge clk) reset = 1'b1;
  endtask
  task automatic wait_press(input int limit);
    lat = 0;
    do begin tick(); lat++; end while (!key_press && lat < limit);
  endtask
  initial begin
    npress = 0;
    #10;
    do_reset();
    // Idle: nothing pressed for ten frames
    run(10 * FR);
    chk("idle_presses", npress, 0);
    // Hold 5: one pulse within the latency bound, none afterwards
    pressed = 16'h0020;
    p0 = npress;
    wait_press(4 * FR + 2);
    chk("k5_in_time", key_press, 1'b1);
    run(10 * FR);
    chk("k5_presses", npress - p0, 1);
    chk("k5_key", key, 4'h5);
    pressed = '0;
    align();
    run(5 * FR);
    // Bouncing key 3 must not commit; holding it afterwards commits once
    p0 = npress;
    for (int i = 0; i < 300; i++) begin
      pressed = ((i / 20) % 2 == 0) ? 16'h0004 : 16'h0000;
      tick();
    end
    chk("bounce_presses", npress - p0, 0);
    pressed = 16'h0004;
    run(6 * FR);
    chk("k3_presses", npress - p0, 1);
    chk("k3_key", key, 4'h3);
    // 5 then directly 6, then release
    pressed = 16'h0020;
    run(5 * FR);
    p0 = npress;
    pressed = 16'h0040;
    run(5 * FR);
    chk("k6_presses", npress - p0, 1);
    chk("k6_key", key, 4'h6);
    pressed = '0;
    p0 = npress;
    lat = 0;
    do begin tick(); lat++; end while (key_valid && lat < 4 * FR + 2);
    chk("rel_valid", key_valid, 1'b0);
    chk("rel_early", lat > 2 * FR, 1'b1);
    run(3 * FR);
    chk("rel_key", key, 4'h6);
    chk("rel_presses", npress - p0, 0);
    // 1 and 9 together, then release 1
    p0 = npress;
    pressed = 16'h0401;
    run(5 * FR);
    chk("m_multi", multi, 1'b1);
    chk("m_valid", key_valid, 1'b0);
    chk("m_presses", npress - p0, 0);
    pressed = 16'h0400;
    run(5 * FR);
    chk("m9_presses", npress - p0, 1);
    chk("m9_key", key, 4'h9);
    chk("m9_multi", multi, 1'b0);
    // Random key patterns with random hold times
    for (int s = 0; s < 24; s++) begin
      pressed = '0;
      repeat ($urandom_range(0, 2)) pressed[$urandom_range(0, 15)] = 1'b1;
      run($urandom_range(15, 160));
    end
    pressed = '0;
    align();
    run(5 * FR);
    // Hold 2, reset during the second frame, then full re-qualification
    pressed = 16'h0002;
    align();
    run(FR + 10);
    do_reset();
    p0 = npress;
    wait_press(4 * FR + 2);
    chk("rq_in_time", key_press, 1'b1);
    chk("rq_not_early", lat >= 3 * FR, 1'b1);
    chk("rq_key", key, 4'h2);
    run(4 * FR);
    chk("rq_presses", npress - p0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
